// File: rtl/gpio_edge_ctrl14.sv
// ---------------------------------------------------------------------------
// gpio_edge_ctrl14 -- parametrised GPIO pin controller with edge interrupts.
//
// Drives the pad output value and active-low output enable from registers,
// samples the asynchronous pad inputs through a 2-flop synchroniser, detects
// per-pin rising/falling edges into a sticky write-1-to-clear status register
// and raises one registered, masked interrupt.
//
// Optional feature: define GPIO_DEBOUNCE_EN to insert a per-pin debounce
// counter between the synchroniser and DIN (a level must persist DB_CYCLES
// cycles before DIN follows it). Without the macro DIN is the synchroniser
// output and no counters exist.
//
// Ports:
//   pclk14          clock
//   n_p_reset14     asynchronous active-low reset
//   reg_sel         register access strobe (one cycle per access)
//   reg_write       1 = write, 0 = read
//   reg_addr        register byte address (bits [1:0] ignored)
//   reg_wdata       write data
//   reg_rdata       registered read data, valid the cycle after a read strobe
//   gpio_pin_in14   asynchronous pad inputs
//   gpio_pin_out14  pad output values (DOUT)
//   n_gpio_pin_oe14 pad output enables, active-low (~OE)
//   gpio_irq        combined registered interrupt
//
// Register map: 0x00 DOUT, 0x04 OE, 0x08 DIN (RO), 0x0C RISE_EN,
//               0x10 FALL_EN, 0x14 INT_MASK, 0x18 INT_STAT (W1C).
// ---------------------------------------------------------------------------
module gpio_edge_ctrl14 #(
  parameter int GPIO_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DB_CYCLES  = 4
) (
  input  logic                  pclk14,
  input  logic                  n_p_reset14,
  input  logic                  reg_sel,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [GPIO_WIDTH-1:0] reg_wdata,
  output logic [GPIO_WIDTH-1:0] reg_rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_pin_in14,
  output logic [GPIO_WIDTH-1:0] gpio_pin_out14,
  output logic [GPIO_WIDTH-1:0] n_gpio_pin_oe14,
  output logic                  gpio_irq
);

  localparam int IW = ADDR_WIDTH - 2;

  // Word index of each register (byte address >> 2).
  localparam logic [IW-1:0] IDX_DOUT = IW'(0);
  localparam logic [IW-1:0] IDX_OE   = IW'(1);
  localparam logic [IW-1:0] IDX_DIN  = IW'(2);
  localparam logic [IW-1:0] IDX_RISE = IW'(3);
  localparam logic [IW-1:0] IDX_FALL = IW'(4);
  localparam logic [IW-1:0] IDX_MASK = IW'(5);
  localparam logic [IW-1:0] IDX_STAT = IW'(6);

  logic [IW-1:0] reg_idx;
  logic          wr_en;
  logic          rd_en;
  logic          unused_addr_bits;

  assign reg_idx          = reg_addr[ADDR_WIDTH-1:2];
  assign wr_en            = reg_sel & reg_write;
  assign rd_en            = reg_sel & ~reg_write;
  assign unused_addr_bits = ^reg_addr[1:0];

  logic [GPIO_WIDTH-1:0] dout_q, oe_q, rise_en_q, fall_en_q, int_mask_q;
  logic [GPIO_WIDTH-1:0] int_stat_q, int_stat_d;
  logic [GPIO_WIDTH-1:0] rdata_q, rdata_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [GPIO_WIDTH-1:0] din;
  logic [GPIO_WIDTH-1:0] rise, fall, clr;
  logic                  irq_q;

  // -------------------------------------------------------------------------
  // Optional debounce stage between the synchroniser and DIN.
  // -------------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [GPIO_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [GPIO_WIDTH-1:0]         din_q, din_d;

  // The counter measures how long sync2 has disagreed with din. Any return
  // to agreement (a glitch ending) restarts it, so only a level held for
  // DB_CYCLES cycles gets through.
  always_comb begin
    cnt_d = cnt_q;
    din_d = din_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (sync2_q[i] == din_q[i]) begin
        cnt_d[i] = '0;
      end else begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          din_d[i] = sync2_q[i];
        end
        if (cnt_q[i] != CW'(DB_CYCLES)) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      cnt_q <= '0;
      din_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      din_q <= din_d;
    end
  end

  assign din = din_q;
`else
  localparam int UNUSED_DB_CYCLES = DB_CYCLES;

  assign din = sync2_q;
`endif

  // -------------------------------------------------------------------------
  // Edge detection and sticky status.
  // -------------------------------------------------------------------------
  assign rise = din & ~prev_q & rise_en_q;
  assign fall = ~din & prev_q & fall_en_q;
  assign clr  = (wr_en && (reg_idx == IDX_STAT)) ? reg_wdata : '0;

  // Set is OR-ed in after the clear, so a new edge beats a simultaneous W1C.
  assign int_stat_d = (int_stat_q & ~clr) | rise | fall;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    case (reg_idx)
      IDX_DOUT: rdata_d = dout_q;
      IDX_OE:   rdata_d = oe_q;
      IDX_DIN:  rdata_d = din;
      IDX_RISE: rdata_d = rise_en_q;
      IDX_FALL: rdata_d = fall_en_q;
      IDX_MASK: rdata_d = int_mask_q;
      IDX_STAT: rdata_d = int_stat_q;
      default:  rdata_d = '0;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      dout_q     <= '0;
      oe_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      int_mask_q <= '0;
      int_stat_q <= '0;
      rdata_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_idx)
          IDX_DOUT: dout_q     <= reg_wdata;
          IDX_OE:   oe_q       <= reg_wdata;
          IDX_RISE: rise_en_q  <= reg_wdata;
          IDX_FALL: fall_en_q  <= reg_wdata;
          IDX_MASK: int_mask_q <= reg_wdata;
          default:  ;
        endcase
      end
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
      sync1_q    <= gpio_pin_in14;
      sync2_q    <= sync1_q;
      prev_q     <= din;
      int_stat_q <= int_stat_d;
      irq_q      <= |(int_stat_q & int_mask_q);
    end
  end

  assign gpio_pin_out14  = dout_q;
  assign n_gpio_pin_oe14 = ~oe_q;
  assign reg_rdata       = rdata_q;
  assign gpio_irq        = irq_q;

endmodule
